// File: rtl/ripple_cnt_sched.sv
// Round-robin scheduler sharing one external ripple counter between NREQ requesters.
// Optional overflow detection is enabled by defining RIPPLE_CNT_SCHED_OVF_EN.
module ripple_cnt_sched #(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned SETTLE = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [7:0]              win_len,
    input  logic [WIDTH-1:0]        cnt_q,
    output logic [NREQ-1:0]         gnt,
    output logic                    cnt_rst,
    output logic                    cnt_en,
    output logic [WIDTH-1:0]        result,
    output logic                    result_valid,
    output logic [$clog2(NREQ)-1:0] result_id,
    output logic                    result_ovf,
    output logic                    busy
);

    localparam int unsigned IDW = $clog2(NREQ);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_COUNT,
        S_SETTLE,
        S_CAPTURE
    } state_t;

    state_t           state_q, state_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [IDW-1:0]   idx_q, idx_d;
    logic [IDW-1:0]   rr_q, rr_d;
    logic [7:0]       win_q, win_d;
    logic [7:0]       tmr_q, tmr_d;
    logic             cnt_rst_q, cnt_en_q;
    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] result_q;
    logic [IDW-1:0]   result_id_q;
    logic             result_valid_q;

    logic             pick_found;
    logic [IDW-1:0]   pick_idx;
    logic [IDW-1:0]   cand;
    int unsigned      arb_j;

    // First set request at or after rr_q, wrapping modulo NREQ.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        arb_j      = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            arb_j = 32'(rr_q) + i;
            if (arb_j >= NREQ) begin
                arb_j = arb_j - NREQ;
            end
            cand = arb_j[IDW-1:0];
            if (!pick_found && req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        rr_d    = rr_q;
        win_d   = win_q;
        tmr_d   = tmr_q;
        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    state_d         = S_CLEAR;
                    gnt_d           = '0;
                    gnt_d[pick_idx] = 1'b1;
                    idx_d           = pick_idx;
                    win_d           = win_len;
                end
            end
            S_CLEAR: begin
                if (win_q == 8'd0) begin
                    state_d = S_SETTLE;
                    tmr_d   = 8'(SETTLE - 1);
                end else begin
                    state_d = S_COUNT;
                    tmr_d   = win_q - 8'd1;
                end
            end
            S_COUNT: begin
                if (tmr_q == 8'd0) begin
                    state_d = S_SETTLE;
                    tmr_d   = 8'(SETTLE - 1);
                end else begin
                    tmr_d = tmr_q - 8'd1;
                end
            end
            S_SETTLE: begin
                if (tmr_q == 8'd0) begin
                    state_d = S_CAPTURE;
                end else begin
                    tmr_d = tmr_q - 8'd1;
                end
            end
            S_CAPTURE: begin
                state_d = S_IDLE;
                gnt_d   = '0;
                if (idx_q == IDW'(NREQ - 1)) begin
                    rr_d = '0;
                end else begin
                    rr_d = idx_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            gnt_q          <= '0;
            idx_q          <= '0;
            rr_q           <= '0;
            win_q          <= '0;
            tmr_q          <= '0;
            cnt_rst_q      <= 1'b1;
            cnt_en_q       <= 1'b0;
            sync1_q        <= '0;
            sync2_q        <= '0;
            result_q       <= '0;
            result_id_q    <= '0;
            result_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            idx_q     <= idx_d;
            rr_q      <= rr_d;
            win_q     <= win_d;
            tmr_q     <= tmr_d;
            cnt_rst_q <= (state_d == S_CLEAR);
            cnt_en_q  <= (state_d == S_COUNT);
            // Counter is known zero after CLEAR; flush stale samples from the previous window.
            if (state_q == S_CLEAR) begin
                sync1_q <= '0;
                sync2_q <= '0;
            end else begin
                sync1_q <= cnt_q;
                sync2_q <= sync1_q;
            end
            result_valid_q <= (state_q == S_CAPTURE);
            if (state_q == S_CAPTURE) begin
                result_q    <= sync2_q;
                result_id_q <= idx_q;
            end
        end
    end

`ifdef RIPPLE_CNT_SCHED_OVF_EN
    logic msb_prev_q, ovf_acc_q, result_ovf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            msb_prev_q   <= 1'b0;
            ovf_acc_q    <= 1'b0;
            result_ovf_q <= 1'b0;
        end else begin
            if (state_q == S_CLEAR) begin
                msb_prev_q <= 1'b0;
                ovf_acc_q  <= 1'b0;
            end else begin
                msb_prev_q <= sync2_q[WIDTH-1];
                if ((state_q == S_COUNT || state_q == S_SETTLE) &&
                    msb_prev_q && !sync2_q[WIDTH-1]) begin
                    ovf_acc_q <= 1'b1;
                end
            end
            if (state_q == S_CAPTURE) begin
                result_ovf_q <= ovf_acc_q;
            end
        end
    end

    assign result_ovf = result_ovf_q;
`else
    assign result_ovf = 1'b0;
`endif

    assign gnt          = gnt_q;
    assign cnt_rst      = cnt_rst_q;
    assign cnt_en       = cnt_en_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign result_id    = result_id_q;
    assign busy         = (state_q != S_IDLE);

endmodule
